snd_cmd_ctrl: RTL and testbench
===============================

SND_CMD_CTRL -- requirements
Module: snd_cmd_ctrl

Interface
REQ-001 Parameter NMIW, default 16: sound-CPU NMI pulse width in CPUCL cycles, legal 1..255.
REQ-002 Parameter IRQDIV, default 50000: sound-CPU periodic IRQ interval in CPUCL cycles, legal 2..65535.
REQ-003 Port CPUCL, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port RESET_N, input, 1: reset, asynchronous and active-low.
REQ-005 Port SNDWR, input, 1: main-CPU write strobe for sound command ($E800); may stay high for several cycles.
REQ-006 Port CPUWD, input, 8: main-CPU write data.
REQ-007 Port SRD, input, 1: sound-CPU command-latch read strobe; may stay high for several cycles.
REQ-008 Port SIACK, input, 1: sound-CPU interrupt acknowledge.
REQ-009 Port SNDDT, output, 8: latched command byte.
REQ-010 Port SNMI, output, 1: sound-CPU NMI, active-high.
REQ-011 Port SIRQ, output, 1: sound-CPU IRQ, active-high, level-held.
REQ-012 Port PEND, output, 1: command written and not yet read.
REQ-013 Port OVF, output, 1: sticky overrun flag.

Function
REQ-014 The block SHALL treat a write as the first cycle of SNDWR high (rising edge against its registered previous value); a held strobe SHALL count as one write.
REQ-015 The block SHALL treat a read as the first cycle of SRD high, detected the same way as a write.
REQ-016 On a write, SNDDT SHALL take CPUWD one cycle later and PEND SHALL be set.
REQ-017 On a write while PEND=1, the block SHALL overwrite SNDDT and set OVF.
REQ-018 On a read, the block SHALL clear PEND and OVF one cycle later; SNDDT SHALL be kept.
REQ-019 On a write and a read in the same cycle, the write SHALL win: PEND stays 1, OVF is unchanged, and a new NMI starts.
REQ-020 The NMI FSM SHALL have states IDLE, ASSERT and WAIT.
  - IDLE -> ASSERT on write; counter loads NMIW.
  - ASSERT: SNMI=1, counter decrements; -> WAIT when it reaches 1.
  - WAIT -> IDLE on read; WAIT -> ASSERT on write, counter reloaded.
REQ-021 A write during ASSERT SHALL reload the counter, so SNMI stays high continuously for NMIW cycles after the last write.
REQ-022 SNMI SHALL be registered and SHALL rise exactly one cycle after the write edge.
REQ-023 A read in ASSERT SHALL NOT truncate the NMI pulse; the FSM SHALL go to IDLE once the pulse ends if PEND=0.
REQ-024 The IRQ timer SHALL be a 16-bit down-counter.
  - Loads IRQDIV-1 and counts one per cycle.
  - At 0 it sets SIRQ and reloads, wrapping without stopping.
REQ-025 SIRQ SHALL stay high until SIACK; SIACK SHALL clear SIRQ on the next cycle.
REQ-026 If SIACK and a timer expiry coincide, SIRQ SHALL end up 1 (set wins).
REQ-027 Timer expiries while SIRQ=1 SHALL NOT queue.

Reset
REQ-028 While RESET_N=0, all outputs SHALL be 0.
  - SNDDT=8'h00, SNMI=0, SIRQ=0, PEND=0, OVF=0.
  - FSM=IDLE, IRQ counter=IRQDIV-1, edge-detect registers=0.
REQ-029 Reset asserted mid-pulse or mid-handshake SHALL abort immediately and asynchronously; nothing SHALL be retained.
REQ-030 After RESET_N rises, a strobe already high SHALL count as a write or read on the first clock.

Structure
REQ-031 Package snd_cmd_pkg SHALL hold:
  - the FSM state enum (IDLE/ASSERT/WAIT);
  - NMIW_DEF=16 and IRQDIV_DEF=50000;
  - the counter width constants (8-bit NMI, 16-bit IRQ).
REQ-032 The IRQ timer and its SIRQ hold/ack logic SHALL be one sub-module, snd_irq_tmr; everything else SHALL stay in snd_cmd_ctrl.

Verification
REQ-033 Single write: SNDWR high 3 cycles, CPUWD=8'h5A.
  - Next cycle: SNDDT=8'h5A, PEND=1.
  - SNMI high exactly 16 cycles, then WAIT.
  - SRD pulse: PEND=0 next cycle, FSM IDLE.
REQ-034 Overrun: write 8'h11, then 8'h22 before any read.
  - SNDDT=8'h22, OVF=1.
  - SNMI stays high continuously for 16 cycles after the second write.
  - Read clears OVF and PEND.
REQ-035 Simultaneous edges: SNDWR and SRD rise in the same cycle with PEND=1, CPUWD=8'h33.
  - PEND=1, SNDDT=8'h33, OVF unchanged, SNMI pulse restarts.
REQ-036 IRQ cadence (IRQDIV=10):
  - SIRQ rises every 10 cycles; with no SIACK it stays high and nothing queues.
  - SIACK coincident with expiry leaves SIRQ=1.
REQ-037 Reset mid-pulse: RESET_N low asynchronously at cycle 5 of SNMI.
  - SNMI, PEND, OVF, SIRQ drop without waiting for a clock.
  - After release the first IRQ comes at exactly IRQDIV cycles.

Source files
------------

// File: rtl/snd_cmd_pkg.sv
// Shared types and constants for the sound-command controller.
package snd_cmd_pkg;

  localparam int unsigned NMIW_DEF   = 16;
  localparam int unsigned IRQDIV_DEF = 50000;

  localparam int unsigned NMI_CNT_W  = 8;
  localparam int unsigned IRQ_CNT_W  = 16;

  typedef enum logic [1:0] {
    NMI_IDLE   = 2'd0,
    NMI_ASSERT = 2'd1,
    NMI_WAIT   = 2'd2
  } nmi_state_e;

endpackage

// File: rtl/snd_irq_tmr.sv
// Free-running periodic IRQ timer with level-held request and acknowledge.
module snd_irq_tmr
  import snd_cmd_pkg::*;
#(
  parameter int unsigned IRQDIV = IRQDIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic iack,
  output logic irq
);

  localparam logic [IRQ_CNT_W-1:0] RELOAD = IRQ_CNT_W'(IRQDIV - 1);

  logic [IRQ_CNT_W-1:0] cnt_q, cnt_d;
  logic                 irq_q, irq_d;

  // Count down, wrap at zero and raise the request; an expiry beats an ack.
  always_comb begin
    cnt_d = cnt_q - IRQ_CNT_W'(1);
    irq_d = irq_q;
    if (cnt_q == '0) begin
      cnt_d = RELOAD;
      irq_d = 1'b1;
    end else if (iack) begin
      irq_d = 1'b0;
    end
  end

  // Timer and request state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: rtl/snd_cmd_ctrl.sv
// Main-to-sound CPU command latch with NMI handshake and periodic IRQ.
module snd_cmd_ctrl
  import snd_cmd_pkg::*;
#(
  parameter int unsigned NMIW   = NMIW_DEF,
  parameter int unsigned IRQDIV = IRQDIV_DEF
) (
  input  logic       CPUCL,
  input  logic       RESET_N,
  input  logic       SNDWR,
  input  logic [7:0] CPUWD,
  input  logic       SRD,
  input  logic       SIACK,
  output logic [7:0] SNDDT,
  output logic       SNMI,
  output logic       SIRQ,
  output logic       PEND,
  output logic       OVF
);

  localparam logic [NMI_CNT_W-1:0] NMI_LOAD = NMI_CNT_W'(NMIW);

  logic                 wr_prev_q, rd_prev_q;
  logic                 wr_edge, rd_edge;
  logic [7:0]           snddt_q, snddt_d;
  logic                 pend_q, pend_d;
  logic                 ovf_q, ovf_d;
  logic                 snmi_q, snmi_d;
  nmi_state_e           state_q, state_d;
  logic [NMI_CNT_W-1:0] cnt_q, cnt_d;

  // Strobe edge detection and command latch; a write beats a read.
  always_comb begin
    wr_edge = SNDWR & ~wr_prev_q;
    rd_edge = SRD & ~rd_prev_q;
    snddt_d = snddt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    if (wr_edge) begin
      snddt_d = CPUWD;
      pend_d  = 1'b1;
      if (!rd_edge) begin
        ovf_d = ovf_q | pend_q;
      end
    end else if (rd_edge) begin
      pend_d = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  // NMI pulse FSM; a write always (re)starts a full-width pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      NMI_IDLE: begin
        if (wr_edge) begin
          state_d = NMI_ASSERT;
          cnt_d   = NMI_LOAD;
        end
      end
      NMI_ASSERT: begin
        if (wr_edge) begin
          cnt_d = NMI_LOAD;
        end else if (cnt_q == NMI_CNT_W'(1)) begin
          // pend_d so a read landing on the last pulse cycle is not lost
          state_d = pend_d ? NMI_WAIT : NMI_IDLE;
        end else begin
          cnt_d = cnt_q - NMI_CNT_W'(1);
        end
      end
      NMI_WAIT: begin
        if (wr_edge) begin
          state_d = NMI_ASSERT;
          cnt_d   = NMI_LOAD;
        end else if (rd_edge) begin
          state_d = NMI_IDLE;
        end
      end
      default: state_d = NMI_IDLE;
    endcase
    snmi_d = (state_d == NMI_ASSERT);
  end

  // Controller state.
  always_ff @(posedge CPUCL or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_prev_q <= 1'b0;
      rd_prev_q <= 1'b0;
      snddt_q   <= '0;
      pend_q    <= 1'b0;
      ovf_q     <= 1'b0;
      snmi_q    <= 1'b0;
      state_q   <= NMI_IDLE;
      cnt_q     <= '0;
    end else begin
      wr_prev_q <= SNDWR;
      rd_prev_q <= SRD;
      snddt_q   <= snddt_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      snmi_q    <= snmi_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  snd_irq_tmr #(
    .IRQDIV(IRQDIV)
  ) u_irq_tmr (
    .clk   (CPUCL),
    .rst_n (RESET_N),
    .iack  (SIACK),
    .irq   (SIRQ)
  );

  assign SNDDT = snddt_q;
  assign SNMI  = snmi_q;
  assign PEND  = pend_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_snd_cmd_ctrl.sv
// Randomized and directed bench for snd_cmd_ctrl against a cycle-level reference model.
module tb_snd_cmd_ctrl;

  localparam int unsigned NMIW   = 16;
  localparam int unsigned IRQDIV = 10;

  logic       CPUCL;
  logic       RESET_N;
  logic       SNDWR;
  logic [7:0] CPUWD;
  logic       SRD;
  logic       SIACK;
  logic [7:0] SNDDT;
  logic       SNMI;
  logic       SIRQ;
  logic       PEND;
  logic       OVF;

  snd_cmd_ctrl #(
    .NMIW   (NMIW),
    .IRQDIV (IRQDIV)
  ) dut (
    .CPUCL   (CPUCL),
    .RESET_N (RESET_N),
    .SNDWR   (SNDWR),
    .CPUWD   (CPUWD),
    .SRD     (SRD),
    .SIACK   (SIACK),
    .SNDDT   (SNDDT),
    .SNMI    (SNMI),
    .SIRQ    (SIRQ),
    .PEND    (PEND),
    .OVF     (OVF)
  );

  initial CPUCL = 1'b0;
  always #5 CPUCL = ~CPUCL;

  int total = 0;
  int bad   = 0;

  // reference model: remaining NMI-high cycles and an absolute cycle count
  logic [7:0] m_data;
  logic       m_pend, m_ovf, m_sirq, m_pwr, m_prd;
  int         m_nmi_left;
  int         m_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_pend = 1'b0; m_ovf = 1'b0; m_sirq = 1'b0;
    m_pwr = 1'b0; m_prd = 1'b0; m_nmi_left = 0; m_cyc = 0;
  endtask

  task automatic model_clock();
    logic wr, rd;
    wr = SNDWR & ~m_pwr;
    rd = SRD & ~m_prd;
    if (wr) begin
      if (m_pend && !rd) m_ovf = 1'b1;
      m_data = CPUWD;
      m_pend = 1'b1;
      m_nmi_left = NMIW;
    end else begin
      if (rd) begin
        m_pend = 1'b0;
        m_ovf  = 1'b0;
      end
      if (m_nmi_left > 0) m_nmi_left--;
    end
    m_cyc++;
    if (m_cyc % IRQDIV == 0) m_sirq = 1'b1;
    else if (SIACK)          m_sirq = 1'b0;
    m_pwr = SNDWR;
    m_prd = SRD;
  endtask

  task automatic check_all();
    chk("snddt", 32'(SNDDT), 32'(m_data));
    chk("snmi",  32'(SNMI),  32'(m_nmi_left > 0));
    chk("sirq",  32'(SIRQ),  32'(m_sirq));
    chk("pend",  32'(PEND),  32'(m_pend));
    chk("ovf",   32'(OVF),   32'(m_ovf));
  endtask

  task automatic step();
    @(posedge CPUCL);
    if (RESET_N) model_clock();
    else         model_reset();
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2 RESET_N = 1'b0;
    #1;
    model_reset();
    chk("rst_snmi",  32'(SNMI),  32'd0);
    chk("rst_pend",  32'(PEND),  32'd0);
    chk("rst_ovf",   32'(OVF),   32'd0);
    chk("rst_sirq",  32'(SIRQ),  32'd0);
    chk("rst_snddt", 32'(SNDDT), 32'd0);
  endtask

  int n_hi;
  int n;
  logic run;

  initial begin
    RESET_N = 1'b0; SNDWR = 1'b0; CPUWD = 8'h00; SRD = 1'b0; SIACK = 1'b0;
    model_reset();
    repeat (3) step();
    RESET_N = 1'b1;

    // first IRQ after reset release lands exactly IRQDIV cycles later
    n = 0;
    for (int i = 0; i < 4 * IRQDIV; i++) begin
      step();
      n++;
      if (SIRQ) break;
    end
    chk("irq_first", 32'(n), 32'(IRQDIV));

    // single write held three cycles
    CPUWD = 8'h5A; SNDWR = 1'b1;
    step();
    chk("wr_data", 32'(SNDDT), 32'h5A);
    chk("wr_pend", 32'(PEND), 32'd1);
    n_hi = int'(SNMI);
    repeat (2) begin step(); n_hi += int'(SNMI); end
    SNDWR = 1'b0;
    repeat (22) begin step(); n_hi += int'(SNMI); end
    chk("nmi_width", 32'(n_hi), 32'(NMIW));
    SRD = 1'b1;
    step();
    chk("rd_pend", 32'(PEND), 32'd0);
    SRD = 1'b0;
    step();

    // overrun: second write before any read
    CPUWD = 8'h11; SNDWR = 1'b1; step(); SNDWR = 1'b0;
    repeat (5) step();
    CPUWD = 8'h22; SNDWR = 1'b1; step(); SNDWR = 1'b0;
    chk("ovr_data", 32'(SNDDT), 32'h22);
    chk("ovr_flag", 32'(OVF), 32'd1);
    n_hi = int'(SNMI); run = SNMI;
    repeat (24) begin
      step();
      if (run && SNMI) n_hi++;
      else run = 1'b0;
    end
    chk("ovr_nmi_width", 32'(n_hi), 32'(NMIW));
    SRD = 1'b1; step(); SRD = 1'b0;
    chk("ovr_clr_ovf",  32'(OVF),  32'd0);
    chk("ovr_clr_pend", 32'(PEND), 32'd0);
    step();

    // simultaneous write and read with PEND=1 and OVF=1
    CPUWD = 8'h44; SNDWR = 1'b1; step(); SNDWR = 1'b0;
    repeat (3) step();
    CPUWD = 8'h55; SNDWR = 1'b1; step(); SNDWR = 1'b0;
    repeat (20) step();
    CPUWD = 8'h33; SNDWR = 1'b1; SRD = 1'b1;
    step();
    SNDWR = 1'b0; SRD = 1'b0;
    chk("sim_pend", 32'(PEND),  32'd1);
    chk("sim_data", 32'(SNDDT), 32'h33);
    chk("sim_ovf",  32'(OVF),   32'd1);
    chk("sim_nmi",  32'(SNMI),  32'd1);
    repeat (20) step();
    SRD = 1'b1; step(); SRD = 1'b0; step();

    // IRQ: no queueing while held, ack clears, ack on expiry loses
    repeat (3 * IRQDIV) step();
    chk("irq_held", 32'(SIRQ), 32'd1);
    for (int i = 0; i < 2 * IRQDIV && ((m_cyc + 1) % IRQDIV) != 3; i++) step();
    SIACK = 1'b1; step(); SIACK = 1'b0;
    chk("irq_ack", 32'(SIRQ), 32'd0);
    step();
    chk("irq_noqueue", 32'(SIRQ), 32'd0);
    for (int i = 0; i < 2 * IRQDIV && ((m_cyc + 1) % IRQDIV) != 0; i++) step();
    SIACK = 1'b1; step(); SIACK = 1'b0;
    chk("irq_ack_coincide", 32'(SIRQ), 32'd1);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) SNDWR = ~SNDWR;
      if ($urandom_range(0, 3) == 0) SRD = ~SRD;
      SIACK = ($urandom_range(0, 4) == 0);
      CPUWD = 8'($urandom);
      step();
    end
    SNDWR = 1'b0; SRD = 1'b0; SIACK = 1'b0;
    step();

    // reset mid-pulse, then strobe already high at release
    CPUWD = 8'h66; SNDWR = 1'b1; step(); SNDWR = 1'b0;
    repeat (4) step();
    async_reset();
    repeat (3) step();
    CPUWD = 8'h77; SNDWR = 1'b1;
    RESET_N = 1'b1;
    step();
    SNDWR = 1'b0;
    chk("rel_wr_pend", 32'(PEND),  32'd1);
    chk("rel_wr_nmi",  32'(SNMI),  32'd1);
    chk("rel_wr_data", 32'(SNDDT), 32'h77);
    n = 1;
    for (int i = 0; i < 4 * IRQDIV && !SIRQ; i++) begin
      step();
      n++;
    end
    chk("irq_first_after_abort", 32'(n), 32'(IRQDIV));
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
